// File: rtl/sdram_init_seq_pkg.sv
// sdram_pkg: shared definitions for the SDRAM power-up sequencer and the
// SDRAM controller.
//   - 4-bit command encodings, ordered {cs_n, ras_n, cas_n, we_n}
//   - state enumeration of the initialisation FSM
//   - max_int helper, used to size the shared wait counter
package sdram_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_INHIBIT      = 4'b1111;
  localparam cmd_t CMD_NOP          = 4'b0111;
  localparam cmd_t CMD_PRECHARGE    = 4'b0010;
  localparam cmd_t CMD_AUTO_REFRESH = 4'b0001;
  localparam cmd_t CMD_LOAD_MODE    = 4'b0000;

  typedef enum logic [3:0] {
    ST_WAIT_LOCK = 4'd0,
    ST_POWERUP   = 4'd1,
    ST_PRECHARGE = 4'd2,
    ST_WAIT_RP   = 4'd3,
    ST_REFRESH   = 4'd4,
    ST_WAIT_RFC  = 4'd5,
    ST_LOAD_MODE = 4'd6,
    ST_WAIT_MRD  = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_init_seq_sync.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; the output resets to 0
//   d     - asynchronous input
//   q     - d, synchronised to clk (two cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture; the first stage may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDRAM power-up initialisation sequencer.
// After PLL lock it waits T_POWERUP cycles and then issues:
//   PRECHARGE-ALL, REFRESH_NUM x AUTO-REFRESH, LOAD-MODE.
// It then raises init_done. If lock is lost, the sequencer returns to
// command-inhibit and restarts the full sequence on re-lock.
// Ports:
//   clk, rst_n         - PLL SDRAM-domain clock, async active-low reset
//   pll_locked         - PLL lock flag, asynchronous to clk
//   sdram_cke/cs_n/ras_n/cas_n/we_n/addr/ba - registered SDRAM command bus
//   init_done          - level, high once the sequence has completed
// T_RP, T_RFC and T_MRD must be at least 2. REFRESH_NUM must be at least 1.
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int                T_POWERUP   = 30000,
  parameter int                T_RP        = 3,
  parameter int                T_RFC       = 9,
  parameter int                T_MRD       = 2,
  parameter int                REFRESH_NUM = 8,
  parameter int                ADDR_W      = 13,
  parameter int                BA_W        = 2,
  parameter logic [ADDR_W-1:0] MODE_REG    = ADDR_W'(13'h032)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_ba,
  output logic              init_done
);

  localparam int CNT_MAX = max_int(max_int(T_POWERUP, T_RFC), max_int(T_RP, T_MRD));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REF_W   = $clog2(REFRESH_NUM + 1);
  // PRECHARGE-ALL: A10 high, every other address bit low.
  localparam logic [ADDR_W-1:0] PRE_ADDR = ADDR_W'(11'h400);

  logic              lock_s;
  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [REF_W-1:0]  ref_cnt_r;
  cmd_t              cmd_r;
  logic              cke_r;
  logic [ADDR_W-1:0] addr_r;
  logic [BA_W-1:0]   ba_r;
  logic              init_done_r;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Sequencer FSM. The outputs are registered together with the state, so the
  // bus always shows the command that belongs to the current state.
  // Each wait state is entered one cycle after its command and is loaded with
  // T-2. This makes the next command appear exactly T cycles after the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_WAIT_LOCK;
      cnt_r       <= {CNT_W{1'b0}};
      ref_cnt_r   <= {REF_W{1'b0}};
      cmd_r       <= CMD_INHIBIT;
      cke_r       <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      ba_r        <= {BA_W{1'b0}};
      init_done_r <= 1'b0;
    end else if (!lock_s && (state_r != ST_WAIT_LOCK)) begin
      // Lock lost: abandon the sequence. It never resumes part-way.
      state_r     <= ST_WAIT_LOCK;
      cnt_r       <= {CNT_W{1'b0}};
      ref_cnt_r   <= {REF_W{1'b0}};
      cmd_r       <= CMD_INHIBIT;
      cke_r       <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      ba_r        <= {BA_W{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      // Defaults: a NOP with the clock enabled. States override as needed.
      cmd_r       <= CMD_NOP;
      cke_r       <= 1'b1;
      addr_r      <= {ADDR_W{1'b0}};
      ba_r        <= {BA_W{1'b0}};
      init_done_r <= 1'b0;
      case (state_r)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_r <= ST_POWERUP;
            cnt_r   <= CNT_W'(T_POWERUP - 1);
          end else begin
            cmd_r <= CMD_INHIBIT;
            cke_r <= 1'b0;
          end
        end
        ST_POWERUP: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= ST_PRECHARGE;
            cmd_r   <= CMD_PRECHARGE;
            addr_r  <= PRE_ADDR;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_PRECHARGE: begin
          state_r   <= ST_WAIT_RP;
          cnt_r     <= CNT_W'(T_RP - 2);
          ref_cnt_r <= {REF_W{1'b0}};
        end
        ST_WAIT_RP: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r   <= ST_REFRESH;
            cmd_r     <= CMD_AUTO_REFRESH;
            ref_cnt_r <= ref_cnt_r + REF_W'(1);
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_REFRESH: begin
          state_r <= ST_WAIT_RFC;
          cnt_r   <= CNT_W'(T_RFC - 2);
        end
        ST_WAIT_RFC: begin
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else if (ref_cnt_r == REF_W'(REFRESH_NUM)) begin
            state_r <= ST_LOAD_MODE;
            cmd_r   <= CMD_LOAD_MODE;
            addr_r  <= MODE_REG;
          end else begin
            // ref_cnt_r counts the refreshes issued so far.
            state_r   <= ST_REFRESH;
            cmd_r     <= CMD_AUTO_REFRESH;
            ref_cnt_r <= ref_cnt_r + REF_W'(1);
          end
        end
        ST_LOAD_MODE: begin
          state_r <= ST_WAIT_MRD;
          cnt_r   <= CNT_W'(T_MRD - 2);
        end
        ST_WAIT_MRD: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r     <= ST_DONE;
            init_done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_DONE: begin
          init_done_r <= 1'b1;
        end
        default: begin
          state_r <= ST_WAIT_LOCK;
          cmd_r   <= CMD_INHIBIT;
          cke_r   <= 1'b0;
        end
      endcase
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_r;
  assign sdram_cke  = cke_r;
  assign sdram_addr = addr_r;
  assign sdram_ba   = ba_r;
  assign init_done  = init_done_r;

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq: scoreboard bench for sdram_init_seq.
// The stimulus process pushes the expected bus changes into a queue. Each
// entry holds an edge number and a bus snapshot. The monitor samples the bus
// on every falling edge. Whenever the snapshot differs from the previous one,
// the monitor pops the queue and compares the entry with the observed change.
// Any change that is not in the queue is therefore caught, including a command
// where a NOP is required.
module tb_sdram_init_seq;

  localparam int TPU  = 100;
  localparam int TRP  = 3;
  localparam int TRFC = 9;
  localparam int TMRD = 2;
  localparam int NREF = 8;
  localparam int NEVER = 1 << 30;

  localparam logic [3:0] C_INH = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_AR  = 4'b0001;
  localparam logic [3:0] C_LM  = 4'b0000;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        cke;
    logic        done;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } ev_t;

  localparam snap_t RST_SNAP = '{cmd: C_INH, addr: 13'h000, ba: 2'b00, cke: 1'b0, done: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pll_locked;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        init_done;

  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;
  logic finish_req = 1'b0;
  ev_t  exp_q[$];
  snap_t cur;

  sdram_init_seq #(
    .T_POWERUP   (TPU),
    .T_RP        (TRP),
    .T_RFC       (TRFC),
    .T_MRD       (TMRD),
    .REFRESH_NUM (NREF),
    .ADDR_W      (13),
    .BA_W        (2),
    .MODE_REG    (13'h032)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .sdram_cke   (sdram_cke),
    .sdram_cs_n  (sdram_cs_n),
    .sdram_ras_n (sdram_ras_n),
    .sdram_cas_n (sdram_cas_n),
    .sdram_we_n  (sdram_we_n),
    .sdram_addr  (sdram_addr),
    .sdram_ba    (sdram_ba),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  assign cur = '{cmd: {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n},
                 addr: sdram_addr, ba: sdram_ba, cke: sdram_cke, done: init_done};

  function automatic snap_t mk(input logic [3:0] c, input logic [12:0] a,
                               input logic k, input logic d);
    snap_t s;
    s.cmd = c; s.addr = a; s.ba = 2'b00; s.cke = k; s.done = d;
    return s;
  endfunction

  task automatic push_ev(input int cyc, input snap_t s);
    ev_t e;
    e.cyc = cyc; e.s = s;
    exp_q.push_back(e);
  endtask

  // Expected bus changes for a full sequence whose first lock-sampling edge
  // is e0. Only the changes strictly before edge 'stop' are queued.
  task automatic push_seq(input int e0, input int stop);
    int p, r;
    if (e0 + 2 < stop) push_ev(e0 + 2, mk(C_NOP, 13'h000, 1'b1, 1'b0));
    p = e0 + 2 + TPU;
    if (p < stop)     push_ev(p,     mk(C_PRE, 13'h400, 1'b1, 1'b0));
    if (p + 1 < stop) push_ev(p + 1, mk(C_NOP, 13'h000, 1'b1, 1'b0));
    r = p + TRP;
    for (int i = 0; i < NREF; i++) begin
      if (r < stop)     push_ev(r,     mk(C_AR,  13'h000, 1'b1, 1'b0));
      if (r + 1 < stop) push_ev(r + 1, mk(C_NOP, 13'h000, 1'b1, 1'b0));
      r = r + TRFC;
    end
    if (r < stop)        push_ev(r,        mk(C_LM,  13'h032, 1'b1, 1'b0));
    if (r + 1 < stop)    push_ev(r + 1,    mk(C_NOP, 13'h000, 1'b1, 1'b0));
    if (r + TMRD < stop) push_ev(r + TMRD, mk(C_NOP, 13'h000, 1'b1, 1'b1));
  endtask

  // Return 1 ns after edge t has occurred.
  task automatic at_edge(input int t);
    while (edge_n < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stimulus
  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    // Lock held high during reset; release after edge 4, so E0 = 5.
    at_edge(4);
    push_seq(5, NEVER);
    rst_n = 1'b0;
    rst_n = 1'b1;
    // Lock loss after init_done: F = 200, INHIBIT at 202. Re-lock with E0 = 220.
    at_edge(199);
    push_ev(202, RST_SNAP);
    pll_locked = 1'b0;
    at_edge(219);
    push_seq(220, NEVER);
    pll_locked = 1'b1;
    // Lock loss at E130 during refresh. Re-lock with E0 = 200 relative (630).
    at_edge(409);
    push_ev(412, RST_SNAP);
    pll_locked = 1'b0;
    at_edge(429);
    push_seq(430, 430 + 132);
    pll_locked = 1'b1;
    at_edge(430 + 129);
    push_ev(430 + 132, RST_SNAP);
    pll_locked = 1'b0;
    at_edge(629);
    push_seq(630, NEVER);
    pll_locked = 1'b1;
    // Asynchronous reset between E110 and E111, then release with lock held.
    at_edge(819);
    push_ev(822, RST_SNAP);
    pll_locked = 1'b0;
    at_edge(839);
    push_seq(840, 950);
    pll_locked = 1'b1;
    at_edge(950);
    push_ev(950, RST_SNAP);
    #2 rst_n = 1'b0;
    at_edge(953);
    push_seq(954, NEVER);
    rst_n = 1'b1;
    // One-cycle lock glitch from WAIT_LOCK: a single POWERUP cycle, then INHIBIT.
    at_edge(1149);
    push_ev(1152, RST_SNAP);
    pll_locked = 1'b0;
    at_edge(1169);
    push_ev(1172, mk(C_NOP, 13'h000, 1'b1, 1'b0));
    push_ev(1173, RST_SNAP);
    pll_locked = 1'b1;
    at_edge(1170);
    pll_locked = 1'b0;
    at_edge(1300);
    finish_req = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    snap_t prev;
    ev_t   e;
    prev = RST_SNAP;
    #2;
    forever begin
      @(negedge clk or negedge rst_n);
      if (clk == 1'b1) begin
        // Reset asserted mid-cycle: outputs must already hold reset values.
        #1;
        total++;
        if (cur !== RST_SNAP) begin
          bad++;
          $display("FAIL async_reset @%0d: got %h want %h", edge_n, cur, RST_SNAP);
        end
      end else begin
        if (!rst_n) begin
          total++;
          if (cur !== RST_SNAP) begin
            bad++;
            $display("FAIL reset_vals @%0d: got %h want %h", edge_n, cur, RST_SNAP);
          end
        end
        if (cur !== prev) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_change @%0d: got cmd=%b addr=%h ba=%b cke=%b done=%b, want no change",
                     edge_n, cur.cmd, cur.addr, cur.ba, cur.cke, cur.done);
          end else begin
            e = exp_q.pop_front();
            if ((e.cyc != edge_n) || (e.s !== cur)) begin
              bad++;
              $display("FAIL bus_event: got E%0d cmd=%b addr=%h ba=%b cke=%b done=%b, want E%0d cmd=%b addr=%h ba=%b cke=%b done=%b",
                       edge_n, cur.cmd, cur.addr, cur.ba, cur.cke, cur.done,
                       e.cyc, e.s.cmd, e.s.addr, e.s.ba, e.s.cke, e.s.done);
            end
          end
        end
        prev = cur;
        if (finish_req) begin
          total++;
          if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events: got %0d pending, want 0 (next E%0d)",
                     exp_q.size(), exp_q[0].cyc);
          end
          $display("test done: total=%0d bad=%0d", total, bad);
          $finish;
        end
      end
    end
  end

endmodule
